// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared widths, FSM encoding, trap cause codes and enable polarity for the
// pipeline hazard controller. Imported by pipe_hazard_ctrl and its
// load-use comparator.
// -----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

  localparam int PC_WIDTH           = 32;
  localparam int GPR_ADDR_WIDTH     = 5;
  localparam int DATA_WIDTH_ISA_EXP = 4;

  localparam logic ENABLE = 1'b1;

  // RISC-V mcause encodings used by the trap sequencer.
  localparam logic [DATA_WIDTH_ISA_EXP-1:0] EXP_EBREAK       = 4'd3;
  localparam logic [DATA_WIDTH_ISA_EXP-1:0] EXP_ACCESS_FAULT_CODE = 4'd5;
  localparam logic [DATA_WIDTH_ISA_EXP-1:0] EXP_ECALL        = 4'd11;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TRAP     = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  // An explicit ISA exception outranks ecall/ebreak; ebreak outranks ecall.
  function automatic logic [DATA_WIDTH_ISA_EXP-1:0] trap_code(
    input logic [DATA_WIDTH_ISA_EXP-1:0] exp_code,
    input logic                          ebreak_en
  );
    if (exp_code != '0)  return exp_code;
    else if (ebreak_en)  return EXP_EBREAK;
    else                 return EXP_ECALL;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_load_use_detect
// Combinational load-use comparator: flags when the instruction in ID reads
// the destination of a load still sitting in EX/MEM. x0 never hazards.
// Ports:
//   load_in_ex_mem       valid writing load in EX/MEM
//   ex_dst_addr          its destination register
//   id_rs1_addr/_used    ID source 1 and whether it is read
//   id_rs2_addr/_used    ID source 2 and whether it is read
//   hazard               1 = one bubble required
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl_load_use_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic                      load_in_ex_mem,
  input  logic [GPR_ADDR_WIDTH-1:0] ex_dst_addr,
  input  logic [GPR_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic                      id_rs1_used,
  input  logic [GPR_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic                      id_rs2_used,
  output logic                      hazard
);

  assign hazard = load_in_ex_mem && (ex_dst_addr != '0) &&
                  ((id_rs1_used && (id_rs1_addr == ex_dst_addr)) ||
                   (id_rs2_used && (id_rs2_addr == ex_dst_addr)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush sequencer for the 5-stage pipeline. Handles load-use
// bubbles, data-memory wait (with timeout to an access-fault trap), trap
// sequencing (flush -> commit -> redirect to mtvec) and taken-branch redirects.
//
// Parameters: MEM_TIMEOUT (2..255), EXP_ACCESS_FAULT (cause on timeout).
// Optional build macro: PIPE_HAZARD_CTRL_PERF_CNT_EN adds perf_loaduse_cnt,
//   perf_memwait_cnt and perf_trap_cnt (32-bit, wrapping).
//
// Ports:
//   clk, rst (sync, active high), cpu_en (low freezes FSM/counters)
//   id_*        : ID-stage sources and branch resolution
//   ex_*        : EX/MEM register contents (pc, dst, memory request, traps)
//   mem_ready   : data-memory handshake done
//   mtvec_base  : trap vector
//   *_stall / *_flush : pipeline register controls (flush dominates stall)
//   pc_redirect / redirect_pc : PC redirect request
//   trap_take / trap_cause / trap_epc : trap commit to the CSR unit
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned                     MEM_TIMEOUT      = 16,
  parameter logic [DATA_WIDTH_ISA_EXP-1:0]   EXP_ACCESS_FAULT = EXP_ACCESS_FAULT_CODE
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cpu_en,
  input  logic [GPR_ADDR_WIDTH-1:0]     id_rs1_addr,
  input  logic [GPR_ADDR_WIDTH-1:0]     id_rs2_addr,
  input  logic                          id_rs1_used,
  input  logic                          id_rs2_used,
  input  logic                          id_branch_taken,
  input  logic [PC_WIDTH-1:0]           id_branch_target,
  input  logic                          load_in_ex_mem,
  input  logic [GPR_ADDR_WIDTH-1:0]     ex_dst_addr,
  input  logic                          ex_en,
  input  logic [PC_WIDTH-1:0]           ex_pc,
  input  logic                          ex_memory_rd_en,
  input  logic                          ex_memory_we_en,
  input  logic                          mem_ready,
  input  logic [DATA_WIDTH_ISA_EXP-1:0] ex_exp_code,
  input  logic                          ex_ebreak_en,
  input  logic                          ex_ecall_en,
  input  logic [PC_WIDTH-1:0]           mtvec_base,
  output logic                          if_stall,
  output logic                          id_stall,
  output logic                          ex_stall,
  output logic                          if_flush,
  output logic                          id_flush,
  output logic                          ex_flush,
  output logic                          mem_flush,
  output logic                          pc_redirect,
  output logic [PC_WIDTH-1:0]           redirect_pc,
  output logic                          trap_take,
  output logic [DATA_WIDTH_ISA_EXP-1:0] trap_cause,
  output logic [PC_WIDTH-1:0]           trap_epc
`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_loaduse_cnt,
  output logic [31:0]                   perf_memwait_cnt,
  output logic [31:0]                   perf_trap_cnt
`endif
);

  state_t                          state_q, state_d;
  logic [7:0]                      wait_cnt_q, wait_cnt_d;
  logic [DATA_WIDTH_ISA_EXP-1:0]   trap_cause_q, trap_cause_d;
  logic [PC_WIDTH-1:0]             trap_epc_q, trap_epc_d;

  logic trap_req;
  logic mem_busy;
  logic mem_timeout;
  logic load_use;

  assign trap_req    = ex_en && (ex_ebreak_en || ex_ecall_en || (ex_exp_code != '0));
  assign mem_busy    = ex_en && (ex_memory_rd_en || ex_memory_we_en) && !mem_ready;
  assign mem_timeout = (wait_cnt_q == 8'(MEM_TIMEOUT));

  pipe_hazard_ctrl_load_use_detect u_load_use_detect (
    .load_in_ex_mem (load_in_ex_mem),
    .ex_dst_addr    (ex_dst_addr),
    .id_rs1_addr    (id_rs1_addr),
    .id_rs1_used    (id_rs1_used),
    .id_rs2_addr    (id_rs2_addr),
    .id_rs2_used    (id_rs2_used),
    .hazard         (load_use)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    trap_cause_d = trap_cause_q;
    trap_epc_d   = trap_epc_q;
    if_stall     = 1'b0;
    id_stall     = 1'b0;
    ex_stall     = 1'b0;
    if_flush     = 1'b0;
    id_flush     = 1'b0;
    ex_flush     = 1'b0;
    mem_flush    = 1'b0;
    pc_redirect  = 1'b0;
    redirect_pc  = '0;
    trap_take    = 1'b0;

    unique case (state_q)
      RUN: begin
        if (trap_req) begin
          {if_flush, id_flush, ex_flush} = 3'b111;
          trap_cause_d = trap_code(ex_exp_code, ex_ebreak_en);
          trap_epc_d   = ex_pc;
          state_d      = TRAP;
        end else if (mem_busy) begin
          {if_stall, id_stall, ex_stall} = 3'b111;
          mem_flush  = 1'b1;
          wait_cnt_d = 8'd1;
          state_d    = MEM_WAIT;
        end else if (load_use) begin
          // Bubble goes into EX/MEM; the load advances so the hazard clears.
          if_stall = 1'b1;
          id_stall = 1'b1;
          ex_flush = 1'b1;
        end else if (id_branch_taken) begin
          pc_redirect = 1'b1;
          redirect_pc = id_branch_target;
          id_flush    = 1'b1;
        end
      end

      MEM_WAIT: begin
        {if_stall, id_stall, ex_stall} = 3'b111;
        mem_flush  = 1'b1;
        wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
        if (mem_ready) begin
          state_d = RUN;
        end else if (mem_timeout) begin
          {if_flush, id_flush, ex_flush} = 3'b111;
          trap_cause_d = EXP_ACCESS_FAULT;
          trap_epc_d   = ex_pc;
          state_d      = TRAP;
        end
      end

      TRAP: begin
        trap_take = 1'b1;
        {if_flush, id_flush, ex_flush, mem_flush} = 4'b1111;
        state_d   = REDIRECT;
      end

      REDIRECT: begin
        pc_redirect = 1'b1;
        redirect_pc = mtvec_base;
        if_flush    = 1'b1;
        state_d     = RUN;
      end

      default: state_d = RUN;
    endcase

    // Reset and freeze override whatever the FSM asked for.
    if (rst) begin
      {if_stall, id_stall, ex_stall}               = 3'b000;
      {if_flush, id_flush, ex_flush, mem_flush}    = 4'b0000;
      pc_redirect = 1'b0;
      trap_take   = 1'b0;
    end else if (cpu_en != ENABLE) begin
      {if_stall, id_stall, ex_stall}               = 3'b111;
      {if_flush, id_flush, ex_flush, mem_flush}    = 4'b0000;
      pc_redirect = 1'b0;
      trap_take   = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      wait_cnt_q   <= '0;
      trap_cause_q <= '0;
      trap_epc_q   <= '0;
    end else if (cpu_en == ENABLE) begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      trap_cause_q <= trap_cause_d;
      trap_epc_q   <= trap_epc_d;
    end
  end

  assign trap_cause = trap_cause_q;
  assign trap_epc   = trap_epc_q;

`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
  logic loaduse_bubble;
  assign loaduse_bubble = (state_q == RUN) && !trap_req && !mem_busy && load_use;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_loaduse_cnt <= '0;
      perf_memwait_cnt <= '0;
      perf_trap_cnt    <= '0;
    end else if (cpu_en == ENABLE) begin
      if (loaduse_bubble)       perf_loaduse_cnt <= perf_loaduse_cnt + 32'd1;
      if (state_q == MEM_WAIT)  perf_memwait_cnt <= perf_memwait_cnt + 32'd1;
      if (state_q == TRAP)      perf_trap_cnt    <= perf_trap_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed vectors for pipe_hazard_ctrl (MEM_TIMEOUT = 4). Each stimulus
// cycle pushes its hand-computed expected outputs into a scoreboard queue;
// a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          cpu_en;
  logic [GPR_ADDR_WIDTH-1:0]     id_rs1_addr, id_rs2_addr;
  logic                          id_rs1_used, id_rs2_used;
  logic                          id_branch_taken;
  logic [PC_WIDTH-1:0]           id_branch_target;
  logic                          load_in_ex_mem;
  logic [GPR_ADDR_WIDTH-1:0]     ex_dst_addr;
  logic                          ex_en;
  logic [PC_WIDTH-1:0]           ex_pc;
  logic                          ex_memory_rd_en, ex_memory_we_en;
  logic                          mem_ready;
  logic [DATA_WIDTH_ISA_EXP-1:0] ex_exp_code;
  logic                          ex_ebreak_en, ex_ecall_en;
  logic [PC_WIDTH-1:0]           mtvec_base;
  logic                          if_stall, id_stall, ex_stall;
  logic                          if_flush, id_flush, ex_flush, mem_flush;
  logic                          pc_redirect;
  logic [PC_WIDTH-1:0]           redirect_pc;
  logic                          trap_take;
  logic [DATA_WIDTH_ISA_EXP-1:0] trap_cause;
  logic [PC_WIDTH-1:0]           trap_epc;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .cpu_en(cpu_en),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_branch_taken(id_branch_taken), .id_branch_target(id_branch_target),
    .load_in_ex_mem(load_in_ex_mem), .ex_dst_addr(ex_dst_addr),
    .ex_en(ex_en), .ex_pc(ex_pc),
    .ex_memory_rd_en(ex_memory_rd_en), .ex_memory_we_en(ex_memory_we_en),
    .mem_ready(mem_ready), .ex_exp_code(ex_exp_code),
    .ex_ebreak_en(ex_ebreak_en), .ex_ecall_en(ex_ecall_en),
    .mtvec_base(mtvec_base),
    .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall),
    .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush),
    .mem_flush(mem_flush), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
    .trap_take(trap_take), .trap_cause(trap_cause), .trap_epc(trap_epc)
  );

  // Control vector order: {if_stall,id_stall,ex_stall,if_flush,id_flush,ex_flush,mem_flush}
  localparam logic [6:0] C_NONE  = 7'b000_0000;
  localparam logic [6:0] C_LU    = 7'b110_0010;
  localparam logic [6:0] C_MEM   = 7'b111_0001;
  localparam logic [6:0] C_TOUT  = 7'b111_1111;
  localparam logic [6:0] C_TREQ  = 7'b000_1110;
  localparam logic [6:0] C_TRAP  = 7'b000_1111;
  localparam logic [6:0] C_REDIR = 7'b000_1000;
  localparam logic [6:0] C_BR    = 7'b000_0100;
  localparam logic [6:0] C_FRZ   = 7'b111_0000;

  typedef struct packed {
    logic [6:0]  ctl;
    logic        redir;
    logic [31:0] rpc;
    logic        take;
    logic [3:0]  cause;
    logic [31:0] epc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   vec_idx  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: one expected vector per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check($sformatf("v%0d_ctl", vec_idx),
            {25'd0, if_stall, id_stall, ex_stall, if_flush, id_flush, ex_flush, mem_flush},
            {25'd0, e.ctl});
      check($sformatf("v%0d_redir", vec_idx), {31'd0, pc_redirect}, {31'd0, e.redir});
      if (e.redir) check($sformatf("v%0d_redirect_pc", vec_idx), redirect_pc, e.rpc);
      check($sformatf("v%0d_trap_take", vec_idx), {31'd0, trap_take}, {31'd0, e.take});
      if (e.take) begin
        check($sformatf("v%0d_trap_cause", vec_idx), {28'd0, trap_cause}, {28'd0, e.cause});
        check($sformatf("v%0d_trap_epc", vec_idx), trap_epc, e.epc);
      end
      vec_idx++;
    end
  end

  task automatic cyc(input logic [6:0] ctl, input logic redir = 1'b0,
                     input logic [31:0] rpc = 32'd0, input logic take = 1'b0,
                     input logic [3:0] cause = 4'd0, input logic [31:0] epc = 32'd0);
    exp_t e;
    e = '{ctl: ctl, redir: redir, rpc: rpc, take: take, cause: cause, epc: epc};
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; cpu_en = 1'b1;
    id_rs1_addr = '0; id_rs2_addr = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    id_branch_taken = 1'b0; id_branch_target = '0;
    load_in_ex_mem = 1'b0; ex_dst_addr = '0; ex_en = 1'b0; ex_pc = '0;
    ex_memory_rd_en = 1'b0; ex_memory_we_en = 1'b0; mem_ready = 1'b0;
    ex_exp_code = '0; ex_ebreak_en = 1'b0; ex_ecall_en = 1'b0;
    mtvec_base = 32'h800;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    idle();
    @(posedge clk); #1;

    // Reset, with a pending memory request that must not show through.
    rst = 1'b1; ex_en = 1'b1; ex_memory_rd_en = 1'b1;
    cyc(C_NONE);
    cyc(C_NONE);
    idle();
    cyc(C_NONE);

    // Load-use on rs1, then the load advances.
    load_in_ex_mem = 1'b1; ex_dst_addr = 5'd5; id_rs1_addr = 5'd5; id_rs1_used = 1'b1;
    cyc(C_LU);
    load_in_ex_mem = 1'b0;
    cyc(C_NONE);
    // Load-use on rs2.
    load_in_ex_mem = 1'b1; id_rs1_used = 1'b0; id_rs2_addr = 5'd5; id_rs2_used = 1'b1;
    cyc(C_LU);
    // Matching rs1 that is not read.
    id_rs2_used = 1'b0; id_rs1_used = 1'b0;
    cyc(C_NONE);
    // Destination x0 never hazards.
    ex_dst_addr = 5'd0; id_rs1_addr = 5'd0; id_rs1_used = 1'b1;
    cyc(C_NONE);
    // Load-use beats branch; branch taken the next cycle.
    ex_dst_addr = 5'd7; id_rs1_addr = 5'd7;
    id_branch_taken = 1'b1; id_branch_target = 32'h200;
    cyc(C_LU);
    load_in_ex_mem = 1'b0;
    cyc(C_BR, 1'b1, 32'h200);
    idle();
    cyc(C_NONE);

    // Memory wait: ready low for 3 cycles, then high.
    ex_en = 1'b1; ex_memory_rd_en = 1'b1; ex_pc = 32'h120;
    cyc(C_MEM);
    cyc(C_MEM);
    cyc(C_MEM);
    mem_ready = 1'b1;
    cyc(C_MEM);
    idle();
    cyc(C_NONE);
    // Store that completes immediately: no stall.
    ex_en = 1'b1; ex_memory_we_en = 1'b1; mem_ready = 1'b1;
    cyc(C_NONE);
    idle();

    // Timeout to access-fault trap.
    ex_en = 1'b1; ex_memory_rd_en = 1'b1; ex_pc = 32'h100;
    cyc(C_MEM);
    cyc(C_MEM);
    cyc(C_MEM);
    cyc(C_MEM);
    cyc(C_TOUT);
    cyc(C_TRAP, 1'b0, 32'd0, 1'b1, 4'd5, 32'h100);
    cyc(C_REDIR, 1'b1, 32'h800);
    idle();
    cyc(C_NONE);

    // mem_ready in the timeout cycle wins.
    ex_en = 1'b1; ex_memory_rd_en = 1'b1; ex_pc = 32'h104;
    cyc(C_MEM);
    cyc(C_MEM);
    cyc(C_MEM);
    cyc(C_MEM);
    mem_ready = 1'b1;
    cyc(C_MEM);
    idle();
    cyc(C_NONE);

    // Ecall.
    ex_en = 1'b1; ex_ecall_en = 1'b1; ex_pc = 32'h40;
    cyc(C_TREQ);
    idle();
    cyc(C_TRAP, 1'b0, 32'd0, 1'b1, 4'd11, 32'h40);
    cyc(C_REDIR, 1'b1, 32'h800);
    cyc(C_NONE);
    // Explicit exception code outranks ebreak.
    ex_en = 1'b1; ex_ebreak_en = 1'b1; ex_exp_code = 4'd2; ex_pc = 32'h44;
    cyc(C_TREQ);
    idle();
    cyc(C_TRAP, 1'b0, 32'd0, 1'b1, 4'd2, 32'h44);
    cyc(C_REDIR, 1'b1, 32'h800);
    // Ebreak alone.
    ex_en = 1'b1; ex_ebreak_en = 1'b1; ex_pc = 32'h48;
    cyc(C_TREQ);
    idle();
    cyc(C_TRAP, 1'b0, 32'd0, 1'b1, 4'd3, 32'h48);
    cyc(C_REDIR, 1'b1, 32'h800);
    // Trap request without a valid EX/MEM instruction.
    ex_ecall_en = 1'b1;
    cyc(C_NONE);
    idle();

    // Trap + load-use + branch together: trap path only; requests held
    // through TRAP/REDIRECT are ignored.
    ex_en = 1'b1; ex_ecall_en = 1'b1; ex_pc = 32'h60;
    load_in_ex_mem = 1'b1; ex_dst_addr = 5'd3; id_rs1_addr = 5'd3; id_rs1_used = 1'b1;
    id_branch_taken = 1'b1; id_branch_target = 32'h300;
    cyc(C_TREQ);
    ex_pc = 32'h64;
    cyc(C_TRAP, 1'b0, 32'd0, 1'b1, 4'd11, 32'h60);
    cyc(C_REDIR, 1'b1, 32'h800);
    idle();
    cyc(C_NONE);

    // Reset in MEM_WAIT.
    ex_en = 1'b1; ex_memory_rd_en = 1'b1; ex_pc = 32'h140;
    cyc(C_MEM);
    cyc(C_MEM);
    rst = 1'b1;
    cyc(C_NONE);
    idle();
    cyc(C_NONE);

    // cpu_en low mid-MEM_WAIT freezes the wait counter; timeout slips by
    // the frozen cycles.
    ex_en = 1'b1; ex_memory_rd_en = 1'b1; ex_pc = 32'h180;
    cyc(C_MEM);
    cyc(C_MEM);
    cpu_en = 1'b0; id_branch_taken = 1'b1; id_branch_target = 32'h400;
    cyc(C_FRZ);
    cyc(C_FRZ);
    cyc(C_FRZ);
    cpu_en = 1'b1; id_branch_taken = 1'b0;
    cyc(C_MEM);
    cyc(C_MEM);
    cyc(C_TOUT);
    cyc(C_TRAP, 1'b0, 32'd0, 1'b1, 4'd5, 32'h180);
    cyc(C_REDIR, 1'b1, 32'h800);
    idle();
    cyc(C_NONE);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drain", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline (IF, ID, ID/EX-ALU, EX/MEM, MEM/WB).
- Drives `if_stall`/`id_stall`/`ex_stall` and `if_flush`/`id_flush`/`ex_flush`/`mem_flush` for every pipeline register, including the EX/MEM register.
- Detects load-use hazards and waits on the data-memory handshake, with a timeout.
- Sequences traps (ecall/ebreak/ISA exceptions) and taken branches into PC redirects.
- Sits beside the pipeline registers in the cpu top, replacing ad-hoc stall logic.

Parameters:
- `MEM_TIMEOUT`, 16: max cycles waiting on `mem_ready` before an access-fault trap (range 2..255).
- `EXP_ACCESS_FAULT`, 4'd5: exception code reported on memory timeout.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `cpu_en` in 1: global enable; low freezes the FSM and counters.
- `id_rs1_addr` / `id_rs2_addr` in `GPR_ADDR_WIDTH`: source registers of the instruction in ID.
- `id_rs1_used` / `id_rs2_used` in 1: the ID instruction actually reads rs1/rs2.
- `id_branch_taken` in 1: branch/jump in ID resolved taken.
- `id_branch_target` in `PC_WIDTH`: its target.
- `load_in_ex_mem` in 1: valid writing load held in the EX/MEM register.
- `ex_dst_addr` in `GPR_ADDR_WIDTH`: EX/MEM destination register.
- `ex_en` in 1: EX/MEM holds a valid instruction.
- `ex_pc` in `PC_WIDTH`: PC of that instruction.
- `ex_memory_rd_en` / `ex_memory_we_en` in 1: EX/MEM memory access request.
- `mem_ready` in 1: data-memory handshake complete this cycle.
- `ex_exp_code` in `DATA_WIDTH_ISA_EXP`: exception code; 0 means none.
- `ex_ebreak_en` / `ex_ecall_en` in 1: trap requests.
- `mtvec_base` in `PC_WIDTH`: trap vector.
- `if_stall`, `id_stall`, `ex_stall` out 1: stall controls.
- `if_flush`, `id_flush`, `ex_flush`, `mem_flush` out 1: flush controls.
- `pc_redirect` out 1: PC redirect valid.
- `redirect_pc` out `PC_WIDTH`: redirect target.
- `trap_take` out 1: one-cycle pulse committing a trap to the CSR unit.
- `trap_cause` out `DATA_WIDTH_ISA_EXP`: cause for the CSR unit.
- `trap_epc` out `PC_WIDTH`: EPC for the CSR unit.

Behaviour:
FSM states are `RUN`, `MEM_WAIT`, `TRAP`, `REDIRECT`.

Reset:
- On `rst`, the next edge sets state to `RUN` and clears `wait_cnt` and all registered outputs.
- All stall/flush/redirect/trap outputs are 0 during reset and in the first cycle after reset.

cpu_en low:
- State, counters and registered outputs hold.
- All stalls forced to 1; all flushes, `pc_redirect` and `trap_take` forced to 0.

Trap detection:
- `trap_req = ex_en & (ex_ebreak_en | ex_ecall_en | ex_exp_code != 0)`.

`RUN` state, priority order:
1. `trap_req` → go to `TRAP` next cycle. This cycle: `if_flush`, `id_flush`, `ex_flush` = 1; latch `trap_epc = ex_pc`; latch `trap_cause` = `ex_exp_code` if nonzero, else the ecall/ebreak code from `define.v`.
2. `(ex_memory_rd_en | ex_memory_we_en) & ex_en & !mem_ready` → go to `MEM_WAIT`. This cycle: stall IF/ID/EX, `mem_flush` = 1 (bubble into MEM/WB); `wait_cnt` = 1.
3. Load-use hazard: `load_in_ex_mem & ex_dst_addr != 0 & ((id_rs1_used & rs1 == dst) | (id_rs2_used & rs2 == dst))` → `if_stall`, `id_stall`, `ex_flush` = 1 for exactly one cycle (bubble into EX/MEM). State stays `RUN`. The hazard clears next cycle because the load has advanced.
4. `id_branch_taken` → `pc_redirect` = 1, `redirect_pc = id_branch_target`, `id_flush` = 1 (kills the fetched wrong-path instruction). Same cycle; no state change.
- Branch and load-use in the same cycle: load-use wins and the branch is re-evaluated next cycle.

`MEM_WAIT` state:
- Stall IF/ID/EX, `mem_flush` = 1, `wait_cnt++` (saturating 8-bit).
- `mem_ready` → return to `RUN`; stalls drop the following cycle.
- `wait_cnt == MEM_TIMEOUT` with no `mem_ready` → go to `TRAP`; `trap_cause = EXP_ACCESS_FAULT`, `trap_epc = ex_pc`, flush IF/ID/EX.
- `mem_ready` in the same cycle as the timeout: `mem_ready` wins.

`TRAP` state (1 cycle):
- `trap_take` = 1; `mem_flush` = 1 (the trapping instruction must not write back); `if_flush`/`id_flush`/`ex_flush` = 1.
- Next state: `REDIRECT`.

`REDIRECT` state (1 cycle):
- `pc_redirect` = 1, `redirect_pc = mtvec_base`, `if_flush` = 1.
- Next state: `RUN`.
- Any `trap_req` seen in `TRAP`/`REDIRECT` is ignored (the instruction has already been flushed).

Output timing and stall/flush rule:
- Stall/flush outputs are combinational from state and inputs; `trap_cause`/`trap_epc` are registered.
- Flush dominates stall in the downstream register logic, so simultaneous assertion is legal.

Optional Feature:
`PIPE_HAZARD_CTRL_PERF_CNT_EN`:
- Defined: adds outputs `perf_loaduse_cnt`, `perf_memwait_cnt` and `perf_trap_cnt`, each 32 bits, wrapping. They increment once per load-use bubble cycle, per `MEM_WAIT` cycle and per `trap_take` respectively. Cleared by `rst`; hold while `cpu_en` is low.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared constants in `define.v`: state encodings, ecall/ebreak/access-fault exception codes, `WRITE`/`ENABLE` polarities. Widths come from the existing `PC_WIDTH`, `GPR_ADDR_WIDTH` and `DATA_WIDTH_ISA_EXP`.
- One natural sub-module: `load_use_detect`, the combinational comparator producing the hazard bit.

Test Plan:
1. Load-use: `lw x5` in EX/MEM (`load_in_ex_mem`=1, `ex_dst_addr`=5); ID `add` with `rs1`=5, `rs1_used`=1 → exactly one cycle of `if_stall`=`id_stall`=`ex_flush`=1, then 0. Same with dst=0 → no stall.
2. Memory wait: `ex_memory_rd_en`=1, `mem_ready` low for 3 cycles → stalls high for 4 cycles (entry cycle + 3 wait cycles), `mem_flush` each cycle; stalls drop the cycle after `mem_ready`.
3. Timeout: `MEM_TIMEOUT`=4, `mem_ready` never asserted → `trap_take` pulse with `trap_cause`=5 and `trap_epc`=`ex_pc` (e.g. 0x100); next cycle `pc_redirect`=1 with `redirect_pc`=`mtvec_base` (0x800).
4. Ecall: `ex_en`=1, `ex_ecall_en`=1, `ex_pc`=0x40 → flush IF/ID/EX; next cycle `trap_take`=1 with `trap_epc`=0x40; next cycle redirect to `mtvec_base`; then back in `RUN`.
5. Priority: `trap_req`, load-use and `id_branch_taken` all asserted in one cycle → trap path only, no `pc_redirect` to the branch target.
6. `rst` asserted while in `MEM_WAIT` → next cycle state `RUN`, all outputs 0. `cpu_en`=0 mid-`MEM_WAIT` → `wait_cnt` frozen, all stalls 1.
